serial_adder: RTL

Parametrised bit-serial adder: loads two WIDTH-bit operands and a carry-in on a start strobe, then adds one bit per clock through a single full-adder cell with a registered carry. Result and carry-out are presented with a one-cycle done pulse and held until the next operation. It is the multi-bit, handshaked successor to the team's registered single-bit full-adder stage. It is intended for area-constrained datapaths where WIDTH+1 cycles of latency are acceptable.

---
 rtl/serial_adder.sv | 131 +++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell with a registered carry, WIDTH+1 cycles per operation.
// Define SERIAL_ADDER_SUB_EN to add the sub_i port (a - b - cin via inverted b/cin load).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub_i,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             sum_bit_d;
  logic             carry_d;
  logic [WIDTH-1:0] b_load_d;
  logic             cin_load_d;

  // Returns {carry, sum} of a single-bit full add.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    full_add = {(x & y) | (c & (x ^ y)), x ^ y ^ c};
  endfunction

  // Full-adder cell on the current LSBs plus the operand load path.
  always_comb begin
    {carry_d, sum_bit_d} = full_add(a_sh_q[0], b_sh_q[0], carry_q);
`ifdef SERIAL_ADDER_SUB_EN
    if (sub_i) begin
      b_load_d   = ~b_i;
      cin_load_d = ~cin_i;
    end else begin
      b_load_d   = b_i;
      cin_load_d = cin_i;
    end
`else
    b_load_d   = b_i;
    cin_load_d = cin_i;
`endif
  end

  // Control FSM and datapath registers; start is only honoured outside SHIFT.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      a_sh_q  <= {WIDTH{1'b0}};
      b_sh_q  <= {WIDTH{1'b0}};
      res_q   <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      cnt_q   <= CNT_ZERO;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start_i) begin
            a_sh_q  <= a_i;
            b_sh_q  <= b_load_d;
            carry_q <= cin_load_d;
            cnt_q   <= CNT_ZERO;
            busy_q  <= 1'b1;
            state_q <= S_SHIFT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_SHIFT: begin
          a_sh_q  <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q  <= {1'b0, b_sh_q[WIDTH-1:1]};
          res_q   <= {sum_bit_d, res_q[WIDTH-1:1]};
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            sum_q   <= {sum_bit_d, res_q[WIDTH-1:1]};
            cout_q  <= carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            state_q <= S_SHIFT;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;

endmodule
